divider_16bit: RTL
==================

# divider_16bit

Multi-cycle 16-bit unsigned restoring divider for the ALU level, the inverse of the combinational multiplier/adder path. It computes quotient and remainder by one trial subtraction per cycle and exposes a start/busy/done handshake. The control unit uses it for DIV/MOD opcodes that cannot complete in a single cycle.

## Interface
Parameters:
- WIDTH, 16, operand and result width; only 16 is supported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a division; sampled only when busy=0.
- dividend  input  16  numerator; captured on an accepted start.
- divisor  input  16  denominator; captured on an accepted start.
- quotient  output  16  result; valid while done=1, held until the next accepted start.
- remainder  output  16  result; valid while done=1, held until the next accepted start.
- busy  output  1  high while an iteration is in progress.
- done  output  1  one-cycle pulse when results become valid.
- div_by_zero  output  1  set with done when divisor==0; held with results.
- signed_op  input  1  present only with DIVIDER_SIGNED_EN.

## Operation
- Reset: state IDLE, and quotient, remainder, busy, done, div_by_zero all 0, and the iteration counter all 0.
- States:
  - IDLE: on start=1, capture operands. Go to DONE_ST if divisor==0, otherwise to RUN.
  - RUN: 16 cycles, with a 4-bit counter counting 0..15. At counter 15, go to DONE_ST.
  - DONE_ST: done=1 for exactly one cycle, then go to IDLE. If start=1 in DONE_ST, it is accepted exactly as in IDLE.
- Datapath: registers P (17-bit partial remainder), Q (16-bit) and D (16-bit divisor).
  - On capture: P=0, Q=dividend, D=divisor.
  - Each RUN cycle: shift {P,Q} left by 1, then compute T = P_shifted − {1'b0,D} at 17 bits.
  - If T[16]==0: P=T and Q[0]=1. Otherwise P is unchanged and Q[0]=0.
- On entry to DONE_ST: quotient=Q and remainder=P[15:0].
- Divide by zero: quotient=16'hFFFF, remainder=dividend, div_by_zero=1. RUN is skipped.
- div_by_zero clears on the next accepted start.
- start while busy=1 is ignored; the operation in flight is unaffected.
- rst at any time, including mid-RUN, aborts the operation and restores reset values on the next edge. No done pulse is produced.

## Timing
- Accepted start at edge E0 means:
  - busy=1 in cycles E0+1 .. E0+16.
  - done=1 in cycle E0+17.
  - Latency is 17 cycles, start to done.
- Divide by zero: done=1 in cycle E0+1 and busy stays 0.
- Back-to-back operation: start held high during the DONE_ST cycle launches the next operation. Throughput is one result per 17 cycles.
- Outputs are registered, with no combinational path from inputs to outputs.
- Operand inputs need only be stable at the accepting edge.

## Configuration
- DIVIDER_SIGNED_EN defined:
  - Adds the signed_op port.
  - When signed_op=1 at capture:
    - Operand magnitudes are captured and the sign flags are stored.
    - On entry to DONE_ST, quotient is negated if the operand signs differ.
    - remainder takes the dividend's sign (truncating division).
  - Latency is unchanged.
  - 16'h8000 / 16'hFFFF gives quotient 16'h8000 and remainder 0 (wraps, no flag).
  - Divide by zero behaves the same as in the unsigned case.
- DIVIDER_SIGNED_EN undefined: there is no signed_op port and division is purely unsigned.

## Structure
- Shared include alu_defs.vh holds:
  - state encodings: IDLE=2'd0, RUN=2'd1, DONE_ST=2'd2.
  - ITER_LAST=4'd15.
  - DIV_ZERO_QUOT=16'hFFFF.
- One sub-module, div_step_16bit: combinational, a single restoring step.
  - Inputs: {P,Q} and D.
  - Outputs: next P and Q.
  - Instantiated once and used iteratively.
- The FSM, counter and registers live in divider_16bit.

## Test plan
- 100 / 7, unsigned -> quotient=14, remainder=2, div_by_zero=0; done exactly in cycle E0+17 and busy high for 16 cycles.
- 16'hFFFF / 1 -> quotient=16'hFFFF, remainder=0. Also 3 / 10 -> quotient=0, remainder=3.
- 5 / 0 -> done in cycle E0+1, quotient=16'hFFFF, remainder=5, div_by_zero=1, busy never high.
- start pulsed with new operands in RUN cycle 5 -> ignored; the original result is delivered. Then start held during DONE_ST -> second result 17 cycles later.
- rst asserted in RUN cycle 8 -> all outputs 0 next cycle and no done pulse; a new start then completes normally.
- With DIVIDER_SIGNED_EN, signed_op=1:
  - −7 / 2 -> quotient=16'hFFFD, remainder=16'hFFFF.
  - 16'h8000 / 16'hFFFF -> quotient=16'h8000, remainder=0.

Source files
------------

// File: rtl/divider_16bit_pkg.sv
// Shared encodings and constants for the multi-cycle restoring divider.
// The optional signed mode is enabled with DIVIDER_SIGNED_EN.
package divider_16bit_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE_ST = 2'd2
    } state_t;

    localparam logic [3:0]  ITER_LAST     = 4'd15;
    localparam logic [15:0] DIV_ZERO_QUOT = 16'hFFFF;

    function automatic logic [15:0] neg16(input logic [15:0] x);
        return ~x + 16'd1;
    endfunction

endpackage

// File: rtl/div_step_16bit.sv
// One combinational restoring-division step: shift {P,Q} left, try P-D,
// keep the difference and set the quotient bit when it does not go negative.
module div_step_16bit (
    input  logic [32:0] pq_in,
    input  logic [15:0] d_in,
    output logic [16:0] p_out,
    output logic [15:0] q_out
);

    logic [16:0] p_sh;
    logic [15:0] q_sh;
    logic [16:0] trial;
    logic        unused_p_msb;

    // P is always below D, so its top bit is zero and falls off the shift.
    assign unused_p_msb = pq_in[32];

    always_comb begin
        p_sh  = pq_in[31:15];
        q_sh  = {pq_in[14:0], 1'b0};
        trial = p_sh - {1'b0, d_in};
        p_out = p_sh;
        q_out = q_sh;
        if (!trial[16]) begin
            p_out = trial;
            q_out = {q_sh[15:1], 1'b1};
        end
    end

endmodule

// File: rtl/divider_16bit.sv
// 16-bit restoring divider, one quotient bit per cycle, start/busy/done handshake.
// Define DIVIDER_SIGNED_EN to add the signed_op port (truncating signed division).
module divider_16bit
    import divider_16bit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
`ifdef DIVIDER_SIGNED_EN
    ,
    input  logic             signed_op
`endif
);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [16:0] p_q, p_d;
    logic [15:0] qr_q, qr_d;
    logic [15:0] d_q, d_d;
    logic [15:0] quot_q, quot_d;
    logic [15:0] rem_q, rem_d;
    logic        dbz_q, dbz_d;
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;

    logic        signed_op_i;
    logic        sign_a, sign_b;
    logic [16:0] step_p;
    logic [15:0] step_q;

`ifdef DIVIDER_SIGNED_EN
    assign signed_op_i = signed_op;
`else
    assign signed_op_i = 1'b0;
`endif

    assign sign_a = signed_op_i & dividend[15];
    assign sign_b = signed_op_i & divisor[15];

    div_step_16bit u_step (
        .pq_in (({p_q, qr_q})),
        .d_in  (d_q),
        .p_out (step_p),
        .q_out (step_q)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        p_d        = p_q;
        qr_d       = qr_q;
        d_d        = d_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dbz_d      = dbz_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;

        case (state_q)
            IDLE, DONE_ST: begin
                state_d = IDLE;
                if (start) begin
                    // Magnitudes go through the unsigned core; signs are reapplied at the end.
                    p_d        = '0;
                    qr_d       = sign_a ? neg16(dividend) : dividend;
                    d_d        = sign_b ? neg16(divisor) : divisor;
                    cnt_d      = '0;
                    neg_quot_d = sign_a ^ sign_b;
                    neg_rem_d  = sign_a;
                    dbz_d      = (divisor == '0);
                    if (divisor == '0) begin
                        state_d = DONE_ST;
                        quot_d  = DIV_ZERO_QUOT;
                        rem_d   = dividend;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                p_d   = step_p;
                qr_d  = step_q;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == ITER_LAST) begin
                    state_d = DONE_ST;
                    quot_d  = neg_quot_q ? neg16(step_q) : step_q;
                    rem_d   = neg_rem_q ? neg16(step_p[15:0]) : step_p[15:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            p_q        <= '0;
            qr_q       <= '0;
            d_q        <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            dbz_q      <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            p_q        <= p_d;
            qr_q       <= qr_d;
            d_q        <= d_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dbz_q      <= dbz_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE_ST);

endmodule
